avalon_rsa_mem_slave: RTL and testbench

- Avalon-MM responder (slave) for the 256-bit RSA design master port.
- Local word-addressed scratch memory. It accepts reads and writes from the RSA master and returns pipelined read data with a fixed latency and readdatavalid.
- Provides configurable wait-state and back-pressure behaviour, so the master's waitrequest/readdatavalid handling is exercised on chip and in simulation without DDR3.

---
 rtl/avalon_rsa_mem_slave.sv | 169 ++++++++++++++++
 tb/tb_avalon_rsa_mem_slave.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_rsa_mem_slave.sv
// Avalon-MM scratch-memory responder for the RSA master port: wait-state FSM,
// read back-pressure and a fixed-latency read pipeline. Optional macro AVS_BYTEENABLE_EN adds byte enables.
module avalon_rsa_mem_slave #(
  parameter int DATA_W       = 256,
  parameter int ADDR_W       = 32,
  parameter int DEPTH_LOG2   = 6,
  parameter int READ_LATENCY = 2,
  parameter int MAX_PENDING  = 4,
  parameter int WAIT_CYCLES  = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   avs_address,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [DATA_W-1:0]   avs_writedata,
`ifdef AVS_BYTEENABLE_EN
  input  logic [DATA_W/8-1:0] avs_byteenable,
`endif
  output logic                avs_waitrequest,
  output logic [DATA_W-1:0]   avs_readdata,
  output logic                avs_readdatavalid,
  output logic                err_oob,
  output logic [15:0]         wr_count
);

  localparam int LSB   = $clog2(DATA_W/8);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = $clog2(MAX_PENDING+1);
  localparam int CW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES+1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCEPT} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         pend_q, pend_d;
  logic                  err_q, err_d;
  logic [15:0]           wrc_q, wrc_d;
  logic [DATA_W-1:0]     mem [DEPTH];

  logic                  cmd, bp, drop, wreq;
  logic                  rd_acc, wr_acc, ill_acc, oob;
  logic [DEPTH_LOG2-1:0] idx;
  logic [DATA_W-1:0]     rd_word;
  logic                  addr_unused;

  assign cmd         = avs_read | avs_write;
  assign idx         = avs_address[LSB+DEPTH_LOG2-1:LSB];
  assign oob         = |avs_address[ADDR_W-1:LSB+DEPTH_LOG2];
  assign addr_unused = ^avs_address[LSB-1:0];

  // Back-pressure applies to pure reads only; a read+write is handled as a write.
  assign bp = avs_read & ~avs_write & (pend_q == PW'(MAX_PENDING));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wreq    = 1'b0;
    drop    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd && WAIT_CYCLES != 0) begin
          wreq    = 1'b1;
          cnt_d   = CW'(WAIT_CYCLES - 1);
          state_d = (WAIT_CYCLES == 1) ? S_ACCEPT : S_WAIT;
        end
      end
      S_WAIT: begin
        wreq = 1'b1;
        if (!cmd) begin
          state_d = S_IDLE;
          drop    = 1'b1;
        end else if (cnt_q == CW'(1)) begin
          state_d = S_ACCEPT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_ACCEPT: begin
        if (!cmd) begin
          state_d = S_IDLE;
          drop    = 1'b1;
        end else if (!bp) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (bp || reset) wreq = 1'b1;
  end

  assign avs_waitrequest = wreq;
  assign wr_acc  = avs_write & ~wreq;
  assign rd_acc  = avs_read & ~avs_write & ~wreq;
  assign ill_acc = avs_read & avs_write & ~wreq;

  always_comb begin
    pend_d = pend_q;
    case ({rd_acc, avs_readdatavalid})
      2'b10:   pend_d = pend_q + PW'(1);
      2'b01:   if (pend_q != '0) pend_d = pend_q - PW'(1);
      default: pend_d = pend_q;
    endcase
    err_d = err_q | ((rd_acc | wr_acc) & oob) | ill_acc | drop;
    wrc_d = wr_acc ? wrc_q + 16'd1 : wrc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      err_q   <= 1'b0;
      wrc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      wrc_q   <= wrc_d;
    end
  end

  // Storage is deliberately left unreset; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (wr_acc && !oob) begin
`ifdef AVS_BYTEENABLE_EN
      for (int b = 0; b < DATA_W/8; b++)
        if (avs_byteenable[b]) mem[idx][b*8 +: 8] <= avs_writedata[b*8 +: 8];
`else
      mem[idx] <= avs_writedata;
`endif
    end
  end

  assign rd_word = oob ? '0 : mem[idx];

  // Each stage loads data only behind a valid, so the last stage holds the
  // previous return while readdatavalid is low.
  logic              vld_pipe [READ_LATENCY];
  logic [DATA_W-1:0] dat_pipe [READ_LATENCY];

  for (genvar g = 0; g < READ_LATENCY; g++) begin : g_stage
    logic              in_v;
    logic [DATA_W-1:0] in_d;
    if (g == 0) begin : g_head
      assign in_v = rd_acc;
      assign in_d = rd_word;
    end else begin : g_body
      assign in_v = vld_pipe[g-1];
      assign in_d = dat_pipe[g-1];
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_pipe[g] <= 1'b0;
        dat_pipe[g] <= '0;
      end else begin
        vld_pipe[g] <= in_v;
        if (in_v) dat_pipe[g] <= in_d;
      end
    end
  end

  assign avs_readdatavalid = vld_pipe[READ_LATENCY-1];
  assign avs_readdata      = dat_pipe[READ_LATENCY-1];
  assign err_oob           = err_q;
  assign wr_count          = wrc_q;

endmodule

// File: tb/tb_avalon_rsa_mem_slave.sv
// Directed bench: default-parameter vector table plus hand sequences for
// wait states (WAIT_CYCLES=3), back-pressure (READ_LATENCY=8) and resets.
module tb_avalon_rsa_mem_slave;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic rst0, rd0, wr0, wait0, rdv0, err0;
  logic [31:0] addr0;
  logic [255:0] wdat0, rdat0;
  logic [15:0] wrc0;
  logic rst1, rd1, wr1, wait1, rdv1, err1;
  logic [31:0] addr1;
  logic [255:0] wdat1, rdat1;
  logic [15:0] wrc1;
  logic rst2, rd2, wr2, wait2, rdv2, err2;
  logic [31:0] addr2;
  logic [255:0] wdat2, rdat2;
  logic [15:0] wrc2;
`ifdef AVS_BYTEENABLE_EN
  logic [31:0] be0, be1, be2;
`endif

  avalon_rsa_mem_slave u_dut0 (
    .clk(clk), .reset(rst0), .avs_address(addr0), .avs_read(rd0), .avs_write(wr0),
    .avs_writedata(wdat0),
`ifdef AVS_BYTEENABLE_EN
    .avs_byteenable(be0),
`endif
    .avs_waitrequest(wait0), .avs_readdata(rdat0), .avs_readdatavalid(rdv0),
    .err_oob(err0), .wr_count(wrc0));

  avalon_rsa_mem_slave #(.WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .reset(rst1), .avs_address(addr1), .avs_read(rd1), .avs_write(wr1),
    .avs_writedata(wdat1),
`ifdef AVS_BYTEENABLE_EN
    .avs_byteenable(be1),
`endif
    .avs_waitrequest(wait1), .avs_readdata(rdat1), .avs_readdatavalid(rdv1),
    .err_oob(err1), .wr_count(wrc1));

  avalon_rsa_mem_slave #(.READ_LATENCY(8), .MAX_PENDING(4)) u_dut2 (
    .clk(clk), .reset(rst2), .avs_address(addr2), .avs_read(rd2), .avs_write(wr2),
    .avs_writedata(wdat2),
`ifdef AVS_BYTEENABLE_EN
    .avs_byteenable(be2),
`endif
    .avs_waitrequest(wait2), .avs_readdata(rdat2), .avs_readdatavalid(rdv2),
    .err_oob(err2), .wr_count(wrc2));

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin n_bad++; $display("FAIL %s: got %b want %b", nm, act, exp); end
  endtask
  task automatic chkw(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin n_bad++; $display("FAIL %s: got %h want %h", nm, act, exp); end
  endtask
  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin n_bad++; $display("FAIL %s: got %0d want %0d", nm, act, exp); end
  endtask
  task automatic chki(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin n_bad++; $display("FAIL %s: got %0d want %0d", nm, act, exp); end
  endtask

  task automatic cyc0(input logic r, input logic w, input logic [31:0] a, input logic [255:0] d);
    @(negedge clk);
    rd0 = r; wr0 = w; addr0 = a; wdat0 = d;
    #1;
  endtask

  task automatic rst_dut0();
    @(negedge clk);
    rd0 = 1'b0; wr0 = 1'b0; rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    #1;
  endtask

  typedef struct {
    logic         rd, wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic         e_wait, e_rdv, e_chkd;
    logic [255:0] e_rdata;
    logic         e_err;
    logic [15:0]  e_wrc;
  } vec_t;

  function automatic vec_t mk(logic r, logic w, logic [31:0] a, logic [255:0] d, logic ew,
                              logic ev, logic ec, logic [255:0] ed, logic ee, logic [15:0] ewc);
    vec_t v;
    v.rd = r; v.wr = w; v.addr = a; v.wdata = d; v.e_wait = ew; v.e_rdv = ev;
    v.e_chkd = ec; v.e_rdata = ed; v.e_err = ee; v.e_wrc = ewc;
    return v;
  endfunction

  vec_t tbl [15];
  logic [255:0] A5, FF, D1, H1111;

  initial begin
    A5 = {32{8'hA5}}; FF = {32{8'hFF}}; D1 = {8{32'hDEADBEEF}}; H1111 = 256'h1111;
    // Columns: rd wr addr wdata | wait rdv check_data data err wr_count (sampled before the edge).
    tbl[0]  = mk(0, 0, 32'h0,    '0,    0, 0, 0, '0,    0, 0);
    tbl[1]  = mk(0, 1, 32'h40,   A5,    0, 0, 0, '0,    0, 0);
    tbl[2]  = mk(1, 0, 32'h40,   '0,    0, 0, 0, '0,    0, 1);
    tbl[3]  = mk(1, 0, 32'h7E0,  '0,    0, 0, 0, '0,    0, 1);
    tbl[4]  = mk(1, 0, 32'h800,  '0,    0, 1, 1, A5,    0, 1);
    tbl[5]  = mk(0, 1, 32'h5F,   H1111, 0, 1, 0, '0,    1, 1);
    tbl[6]  = mk(1, 0, 32'h45,   '0,    0, 1, 1, '0,    1, 2);
    tbl[7]  = mk(0, 0, 32'h0,    '0,    0, 0, 1, '0,    1, 2);
    tbl[8]  = mk(0, 0, 32'h0,    '0,    0, 1, 1, H1111, 1, 2);
    tbl[9]  = mk(0, 1, 32'h1040, FF,    0, 0, 1, H1111, 1, 2);
    tbl[10] = mk(1, 0, 32'h1040, '0,    0, 0, 1, H1111, 1, 3);
    tbl[11] = mk(1, 0, 32'h40,   '0,    0, 0, 1, H1111, 1, 3);
    tbl[12] = mk(0, 0, 32'h0,    '0,    0, 1, 1, '0,    1, 3);
    tbl[13] = mk(0, 0, 32'h0,    '0,    0, 1, 1, H1111, 1, 3);
    tbl[14] = mk(0, 0, 32'h0,    '0,    0, 0, 1, H1111, 1, 3);

    rst0 = 1; rd0 = 0; wr0 = 0; addr0 = '0; wdat0 = '0;
    rst1 = 1; rd1 = 0; wr1 = 0; addr1 = '0; wdat1 = '0;
    rst2 = 1; rd2 = 0; wr2 = 0; addr2 = '0; wdat2 = '0;
`ifdef AVS_BYTEENABLE_EN
    be0 = '1; be1 = '1; be2 = '1;
`endif
    repeat (2) @(negedge clk);
    #1;
    chkb("rst.wait", wait0, 1'b1);
    chkb("rst.rdv", rdv0, 1'b0);
    chkw("rst.rdata", rdat0, '0);
    chkb("rst.err", err0, 1'b0);
    chk16("rst.wrc", wrc0, 16'd0);
    rst0 = 0; rst1 = 0; rst2 = 0;

    for (int i = 0; i < 15; i++) begin
      cyc0(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
      chkb($sformatf("v%0d.wait", i), wait0, tbl[i].e_wait);
      chkb($sformatf("v%0d.rdv", i), rdv0, tbl[i].e_rdv);
      if (tbl[i].e_chkd) chkw($sformatf("v%0d.rdata", i), rdat0, tbl[i].e_rdata);
      chkb($sformatf("v%0d.err", i), err0, tbl[i].e_err);
      chk16($sformatf("v%0d.wrc", i), wrc0, tbl[i].e_wrc);
    end

    // Reset clears flags; then an out-of-range write alone sets err and counts.
    rst_dut0();
    chkb("rstA.err", err0, 1'b0);
    chk16("rstA.wrc", wrc0, 16'd0);
    cyc0(0, 1, 32'h2000, A5);
    cyc0(0, 0, 32'h0, '0);
    chkb("oobw.err", err0, 1'b1);
    chk16("oobw.wrc", wrc0, 16'd1);

    // Read+write together behaves as a write with no read return.
    rst_dut0();
    cyc0(1, 1, 32'h20, 256'h1234);
    chkb("ill.wait", wait0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc0(0, 0, 32'h0, '0);
      chkb($sformatf("ill.rdv%0d", k), rdv0, 1'b0);
    end
    chkb("ill.err", err0, 1'b1);
    chk16("ill.wrc", wrc0, 16'd1);
    cyc0(1, 0, 32'h20, '0);
    cyc0(0, 0, 32'h0, '0);
    cyc0(0, 0, 32'h0, '0);
    chkb("ill.rb.rdv", rdv0, 1'b1);
    chkw("ill.rb.data", rdat0, 256'h1234);

    // Two reads in flight, then a one-cycle reset: nothing may return.
    cyc0(1, 0, 32'h20, '0);
    cyc0(1, 0, 32'h40, '0);
    rst_dut0();
    chkb("flush.err", err0, 1'b0);
    chk16("flush.wrc", wrc0, 16'd0);
    chkw("flush.rdata", rdat0, '0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) cyc0(0, 0, 32'h0, '0);
      chkb($sformatf("flush.rdv%0d", k), rdv0, 1'b0);
    end

    // WAIT_CYCLES=3: three stall cycles then one accept cycle, for write and read.
    @(negedge clk);
    wr1 = 1; addr1 = 32'h20; wdat1 = D1;
    for (int c = 0; c < 4; c++) begin
      #1 chkb($sformatf("w3.wr.wait%0d", c), wait1, c < 3);
      @(negedge clk);
    end
    wr1 = 0; rd1 = 1;
    for (int c = 0; c < 4; c++) begin
      #1 chkb($sformatf("w3.rd.wait%0d", c), wait1, c < 3);
      @(negedge clk);
    end
    rd1 = 0;
    #1 chkb("w3.rdv.early", rdv1, 1'b0);
    @(negedge clk);
    #1 chkb("w3.rdv", rdv1, 1'b1);
    chkw("w3.rdata", rdat1, D1);
    chk16("w3.wrc", wrc1, 16'd1);
    chkb("w3.err0", err1, 1'b0);
    @(negedge clk);
    #1 chkb("w3.rdv.after", rdv1, 1'b0);
    // Dropping the command mid-wait is a protocol error.
    @(negedge clk);
    rd1 = 1;
    #1 chkb("w3.drop.wait", wait1, 1'b1);
    @(negedge clk);
    rd1 = 0;
    @(negedge clk);
    #1 chkb("w3.drop.err", err1, 1'b1);

    // READ_LATENCY=8, MAX_PENDING=4: six back-to-back reads.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wr2 = 1; addr2 = 32'(i * 32); wdat2 = 256'(i + 256);
    end
    @(negedge clk);
    wr2 = 0;
    begin
      int idx, nret, first;
      idx = 0; nret = 0; first = -1;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        rd2 = (idx < 6);
        addr2 = 32'(idx * 32);
        #1;
        if (rdv2) begin
          chkw($sformatf("bp.ret%0d", nret), rdat2, 256'(nret + 256));
          if (first < 0) begin
            first = c;
            chki("bp.acc_at_first_rdv", idx, 4);
          end
          nret++;
        end
        if (c < 8) chkb($sformatf("bp.wait%0d", c), wait2, c >= 4);
        if (rd2 && !wait2) idx++;
      end
      rd2 = 0;
      chki("bp.first_rdv_cycle", first, 8);
      chki("bp.accepted", idx, 6);
      chki("bp.returned", nret, 6);
      chk16("bp.wrc", wrc2, 16'd6);
    end

`ifdef AVS_BYTEENABLE_EN
    cyc0(0, 1, 32'h60, FF);
    @(negedge clk);
    wr0 = 1; addr0 = 32'h60; wdat0 = '0; be0 = 32'h0000000F;
    @(negedge clk);
    wr0 = 0; be0 = '1; rd0 = 1;
    cyc0(0, 0, 32'h0, '0);
    cyc0(0, 0, 32'h0, '0);
    chkb("be.rdv", rdv0, 1'b1);
    chkw("be.data", rdat0, {{28{8'hFF}}, 32'h0});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
